// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage MIPS datapath and hazard_ctrl.
// The datapath drives pipeline register fields (master); hazard_ctrl returns stall/flush/forward controls (slave).
interface hazard_ctrl_if;
   logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E;
   logic [4:0]  RegAddr3_E, RegAddr3_M, RegAddr3_W;
   logic        RegWriteEN_E, RegWriteEN_M, RegWriteEN_W;
   logic        Mem2RegSEL_E, PCSrc_M, MulDivStart_E, MulDivUse_D;
   logic        Stall_F, Stall_D, Flush_D, Flush_E, Flush_M;
   logic [1:0]  FwdA_E, FwdB_E;
   logic        MulDivGo, MulDivBusy;
   logic [31:0] StallCount, FlushCount;
   logic [1:0]  md_state;  // MULT/DIV sequencer state: 0 idle, 1 busy, 2 done

   modport master (
      output Rs_D, Rt_D, Rs_E, Rt_E, RegAddr3_E, RegAddr3_M, RegAddr3_W,
             RegWriteEN_E, RegWriteEN_M, RegWriteEN_W, Mem2RegSEL_E, PCSrc_M,
             MulDivStart_E, MulDivUse_D,
      input  Stall_F, Stall_D, Flush_D, Flush_E, Flush_M, FwdA_E, FwdB_E,
             MulDivGo, MulDivBusy, StallCount, FlushCount, md_state
   );

   modport slave (
      input  Rs_D, Rt_D, Rs_E, Rt_E, RegAddr3_E, RegAddr3_M, RegAddr3_W,
             RegWriteEN_E, RegWriteEN_M, RegWriteEN_W, Mem2RegSEL_E, PCSrc_M,
             MulDivStart_E, MulDivUse_D,
      output Stall_F, Stall_D, Flush_D, Flush_E, Flush_M, FwdA_E, FwdB_E,
             MulDivGo, MulDivBusy, StallCount, FlushCount, md_state
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX forwarding, load-use / MULT-DIV stalls, branch flushes, MULT/DIV sequencing.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 8
) (
   input logic         CLOCK,
   input logic         RESET,
   hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   md_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             md_go, md_busy, load_use, md_haz;

   // MEM result is newer than WB, so it wins; $0 is hard-wired and never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       we_m, input logic [4:0] dst_m,
                                          input logic       we_w, input logic [4:0] dst_w);
      if (we_m && dst_m != 5'd0 && dst_m == src)      return 2'b10;
      else if (we_w && dst_w != 5'd0 && dst_w == src) return 2'b01;
      else                                            return 2'b00;
   endfunction

   assign hz.FwdA_E = fwd_sel(hz.Rs_E, hz.RegWriteEN_M, hz.RegAddr3_M, hz.RegWriteEN_W, hz.RegAddr3_W);
   assign hz.FwdB_E = fwd_sel(hz.Rt_E, hz.RegWriteEN_M, hz.RegAddr3_M, hz.RegWriteEN_W, hz.RegAddr3_W);

   assign load_use = hz.Mem2RegSEL_E && hz.RegWriteEN_E && (hz.RegAddr3_E != 5'd0) &&
                     ((hz.RegAddr3_E == hz.Rs_D) || (hz.RegAddr3_E == hz.Rt_D));
   assign md_haz   = hz.MulDivUse_D && (md_busy || md_go);

   // A taken branch must let the target PC load, so it overrides every stall.
   assign hz.Stall_F = (load_use || md_haz) && !hz.PCSrc_M;
   assign hz.Stall_D = (load_use || md_haz) && !hz.PCSrc_M;
   assign hz.Flush_E = hz.PCSrc_M || load_use || md_haz;
   assign hz.Flush_D = hz.PCSrc_M;
   assign hz.Flush_M = hz.PCSrc_M;

   // Go is a single-cycle pulse; Busy covers the MD_LATENCY cycles that follow it.
   assign md_busy       = (state != MD_IDLE);
   assign hz.MulDivGo   = md_go;
   assign hz.MulDivBusy = md_busy;
   assign hz.md_state   = state;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      md_go   = 1'b0;
      case (state)
         MD_IDLE: begin
            // A start squashed by a taken branch never reaches the unit.
            if (RESET && hz.MulDivStart_E && !hz.PCSrc_M) begin
               md_go   = 1'b1;
               cnt_n   = CNT_W'(MD_LATENCY - 2);
               state_n = MD_BUSY;
            end
         end
         MD_BUSY: begin
            if (cnt == '0) state_n = MD_DONE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         MD_DONE: state_n = MD_IDLE;
         default: state_n = MD_IDLE;
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hz.Stall_D) stall_cnt <= stall_cnt + 32'd1;
         if (hz.Flush_D) flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign hz.StallCount = stall_cnt;
   assign hz.FlushCount = flush_cnt;
`else
   assign hz.StallCount = '0;
   assign hz.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LATENCY=4; inputs change on the falling edge, outputs checked 1ns later.
module tb_hazard_ctrl;
   logic CLOCK;
   logic RESET;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] exp_stall_cnt, exp_flush_cnt;
   logic        exp_go, exp_busy, exp_stall;
   logic [1:0]  exp_state;

   hazard_ctrl_if hz();

   hazard_ctrl #(.MD_LATENCY(4), .CNT_W(8)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .hz    (hz)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      hz.Rs_D = 5'd0; hz.Rt_D = 5'd0; hz.Rs_E = 5'd0; hz.Rt_E = 5'd0;
      hz.RegAddr3_E = 5'd0; hz.RegAddr3_M = 5'd0; hz.RegAddr3_W = 5'd0;
      hz.RegWriteEN_E = 1'b0; hz.RegWriteEN_M = 1'b0; hz.RegWriteEN_W = 1'b0;
      hz.Mem2RegSEL_E = 1'b0; hz.PCSrc_M = 1'b0;
      hz.MulDivStart_E = 1'b0; hz.MulDivUse_D = 1'b0;
   endtask

   task automatic chk_ctl(input string tag, input logic sf, input logic sd,
                          input logic fd, input logic fe, input logic fm);
      chk({tag, "_stall_f"}, 32'(hz.Stall_F), 32'(sf));
      chk({tag, "_stall_d"}, 32'(hz.Stall_D), 32'(sd));
      chk({tag, "_flush_d"}, 32'(hz.Flush_D), 32'(fd));
      chk({tag, "_flush_e"}, 32'(hz.Flush_E), 32'(fe));
      chk({tag, "_flush_m"}, 32'(hz.Flush_M), 32'(fm));
   endtask

   initial begin
`ifdef HAZARD_PERF_CNT_EN
      exp_stall_cnt = 32'd3;
      exp_flush_cnt = 32'd1;
`else
      exp_stall_cnt = 32'd0;
      exp_flush_cnt = 32'd0;
`endif
      clr();
      RESET = 1'b0;

      // Reset state
      @(negedge CLOCK); #1;
      chk("rst_busy", 32'(hz.MulDivBusy), 32'd0);
      chk("rst_go", 32'(hz.MulDivGo), 32'd0);
      chk("rst_state", 32'(hz.md_state), 32'd0);
      chk("rst_stallcnt", hz.StallCount, 32'd0);
      chk("rst_flushcnt", hz.FlushCount, 32'd0);
      chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge CLOCK);
      RESET = 1'b1;

      // Forwarding: r3 in both MEM and WB, MEM wins
      @(negedge CLOCK);
      clr();
      hz.Rs_E = 5'd3; hz.Rt_E = 5'd7;
      hz.RegWriteEN_M = 1'b1; hz.RegAddr3_M = 5'd3;
      hz.RegWriteEN_W = 1'b1; hz.RegAddr3_W = 5'd3;
      #1;
      chk("fwdA_mem", 32'(hz.FwdA_E), 32'd2);
      chk("fwdB_none", 32'(hz.FwdB_E), 32'd0);
      // $0 is never forwarded
      hz.Rs_E = 5'd0; hz.RegAddr3_M = 5'd0; hz.RegAddr3_W = 5'd0;
      #1;
      chk("fwdA_r0", 32'(hz.FwdA_E), 32'd0);
      // WB-only match on Rt
      hz.Rt_E = 5'd9; hz.RegAddr3_M = 5'd4; hz.RegAddr3_W = 5'd9;
      #1;
      chk("fwdB_wb", 32'(hz.FwdB_E), 32'd1);
      // MEM address match but write disabled falls back to WB
      hz.Rs_E = 5'd12; hz.RegAddr3_M = 5'd12; hz.RegWriteEN_M = 1'b0; hz.RegAddr3_W = 5'd12;
      #1;
      chk("fwdA_mem_off", 32'(hz.FwdA_E), 32'd1);

      // Load-use #1: LW r5 in EX, ID reads Rt=5
      @(negedge CLOCK);
      clr();
      hz.Mem2RegSEL_E = 1'b1; hz.RegWriteEN_E = 1'b1; hz.RegAddr3_E = 5'd5; hz.Rt_D = 5'd5;
      #1;
      chk_ctl("lu1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      // Load moves to MEM, consumer reaches EX
      @(negedge CLOCK);
      clr();
      hz.RegWriteEN_M = 1'b1; hz.RegAddr3_M = 5'd5; hz.Rt_E = 5'd5;
      #1;
      chk_ctl("lu1_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu1_fwdB", 32'(hz.FwdB_E), 32'd2);

      // Load-use #2 on Rs
      @(negedge CLOCK);
      clr();
      hz.Mem2RegSEL_E = 1'b1; hz.RegWriteEN_E = 1'b1; hz.RegAddr3_E = 5'd17; hz.Rs_D = 5'd17;
      #1;
      chk_ctl("lu2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      // Boundary: load to $0 never stalls
      @(negedge CLOCK);
      hz.RegAddr3_E = 5'd0; hz.Rs_D = 5'd0;
      #1;
      chk_ctl("lu_r0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Load without write enable does not stall
      hz.RegAddr3_E = 5'd8; hz.Rt_D = 5'd8; hz.RegWriteEN_E = 1'b0;
      #1;
      chk_ctl("lu_nowe", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // Load-use #3 on both sources
      @(negedge CLOCK);
      clr();
      hz.Mem2RegSEL_E = 1'b1; hz.RegWriteEN_E = 1'b1; hz.RegAddr3_E = 5'd31;
      hz.Rs_D = 5'd31; hz.Rt_D = 5'd31;
      #1;
      chk_ctl("lu3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

      // Taken branch coincident with load-use: branch wins
      @(negedge CLOCK);
      clr();
      hz.Mem2RegSEL_E = 1'b1; hz.RegWriteEN_E = 1'b1; hz.RegAddr3_E = 5'd6; hz.Rs_D = 5'd6;
      hz.PCSrc_M = 1'b1;
      #1;
      chk_ctl("br_lu", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Performance counters: 3 stalls, 1 flush
      @(negedge CLOCK);
      clr();
      #1;
      chk("perf_stall", hz.StallCount, exp_stall_cnt);
      chk("perf_flush", hz.FlushCount, exp_flush_cnt);

      // MULT then MFLO in ID; branch in cycle 2 must not abort the operation
      for (int i = 0; i < 6; i++) begin
         @(negedge CLOCK);
         clr();
         hz.MulDivStart_E = (i == 0);
         hz.MulDivUse_D   = 1'b1;
         hz.PCSrc_M       = (i == 2);
         #1;
         exp_go    = (i == 0);
         exp_busy  = (i >= 1) && (i <= 4);
         exp_stall = (i <= 4) && (i != 2);
         exp_state = (i == 0 || i == 5) ? 2'd0 : (i == 4) ? 2'd2 : 2'd1;
         chk($sformatf("md_go_%0d", i), 32'(hz.MulDivGo), 32'(exp_go));
         chk($sformatf("md_busy_%0d", i), 32'(hz.MulDivBusy), 32'(exp_busy));
         chk($sformatf("md_stall_%0d", i), 32'(hz.Stall_D), 32'(exp_stall));
         chk($sformatf("md_flush_e_%0d", i), 32'(hz.Flush_E), 32'(i <= 4));
         chk($sformatf("md_state_%0d", i), 32'(hz.md_state), 32'(exp_state));
      end

      // Start squashed by a taken branch
      @(negedge CLOCK);
      clr();
      hz.MulDivStart_E = 1'b1; hz.PCSrc_M = 1'b1;
      #1;
      chk("sq_go", 32'(hz.MulDivGo), 32'd0);
      @(negedge CLOCK);
      clr();
      #1;
      chk("sq_state", 32'(hz.md_state), 32'd0);
      chk("sq_busy", 32'(hz.MulDivBusy), 32'd0);

      // Reset in the middle of BUSY
      @(negedge CLOCK);
      hz.MulDivStart_E = 1'b1;
      #1;
      chk("mr_go", 32'(hz.MulDivGo), 32'd1);
      @(negedge CLOCK);
      hz.MulDivStart_E = 1'b0;
      #1;
      chk("mr_busy1", 32'(hz.MulDivBusy), 32'd1);
      @(negedge CLOCK);
      #1;
      chk("mr_state1", 32'(hz.md_state), 32'd1);
      #2;
      RESET = 1'b0;
      hz.MulDivStart_E = 1'b1;
      #1;
      chk("mr_rst_busy", 32'(hz.MulDivBusy), 32'd0);
      chk("mr_rst_state", 32'(hz.md_state), 32'd0);
      chk("mr_rst_go", 32'(hz.MulDivGo), 32'd0);
      chk("mr_rst_stallcnt", hz.StallCount, 32'd0);
      chk("mr_rst_flushcnt", hz.FlushCount, 32'd0);
      @(negedge CLOCK);
      hz.MulDivStart_E = 1'b0;
      RESET = 1'b1;
      #1;
      chk("mr_post_go", 32'(hz.MulDivGo), 32'd0);
      @(negedge CLOCK);
      #1;
      chk("mr_post_state", 32'(hz.md_state), 32'd0);
      chk("mr_post_busy", 32'(hz.MulDivBusy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
